// File: rtl/p17_usb_pkg.sv
// Shared definitions for the multi-channel bulk endpoint: endpoint field
// width, IN-side transfer states and a constant-foldable clog2.
package p17_usb_pkg;

  localparam int ENDP_W            = 4;
  localparam int BYTE_W            = 8;
  localparam int ENDP_BASE_DEFAULT = 1;

  // IN transfer progress for one channel.
  typedef enum logic [1:0] {
    IN_IDLE     = 2'd0,
    IN_SEND     = 2'd1,
    IN_WAIT_ACK = 2'd2
  } in_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int p17_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/p17_spec_fifo.sv
// Byte FIFO with speculative and committed pointers on both sides.
// Writes land at the speculative write pointer and become readable once
// committed; reads advance a speculative read pointer and only free space
// once committed. Either side can roll its speculative pointer back.
module p17_spec_fifo
  import p17_usb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PW    = p17_clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic              wr_commit_i,
  input  logic              wr_rollback_i,
  input  logic              rd_en_i,
  input  logic              rd_commit_i,
  input  logic              rd_rollback_i,
  output logic [BYTE_W-1:0] rd_data_o,
  output logic [PW-1:0]     wr_spec_o,
  output logic [PW-1:0]     wr_com_o,
  output logic [PW-1:0]     rd_com_o
);

  localparam int AW = PW - 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_spec_q, wr_com_q, rd_spec_q, rd_com_q;
  logic [PW-1:0]     wr_spec_inc, rd_spec_inc;

  // A commit in the same cycle as a data move publishes the moved position.
  assign wr_spec_inc = wr_spec_q + PW'(wr_en_i);
  assign rd_spec_inc = rd_spec_q + PW'(rd_en_i);

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_spec_q[AW-1:0]] <= wr_data_i;
  end

  // Pointer registers: flush empties everything, rollback beats advance.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_spec_q <= '0;
      wr_com_q  <= '0;
      rd_spec_q <= '0;
      rd_com_q  <= '0;
    end else if (flush_i) begin
      wr_spec_q <= '0;
      wr_com_q  <= '0;
      rd_spec_q <= '0;
      rd_com_q  <= '0;
    end else begin
      wr_spec_q <= wr_rollback_i ? wr_com_q : wr_spec_inc;
      if (wr_commit_i) wr_com_q <= wr_spec_inc;
      rd_spec_q <= rd_rollback_i ? rd_com_q : rd_spec_inc;
      if (rd_commit_i) rd_com_q <= rd_spec_inc;
    end
  end

  assign rd_data_o = mem[rd_spec_q[AW-1:0]];
  assign wr_spec_o = wr_spec_q;
  assign wr_com_o  = wr_com_q;
  assign rd_com_o  = rd_com_q;

endmodule

// File: rtl/p17_multi_bulk_endp.sv
// N bulk IN/OUT channel pairs behind one SIE port. Each channel owns an IN
// FIFO (app writes, USB reads with retransmit on a repeated token) and an
// OUT FIFO (USB writes a packet speculatively, app sees it only on commit).
// Handshake: app_in_* and app_out_* follow valid/ready -- a byte moves on a
// rising clock edge where both valid and ready are high; valid never waits
// on ready. On the SIE side an IN byte moves when in_valid_o and in_ready_i
// are both high.
module p17_multi_bulk_endp
  import p17_usb_pkg::*;
#(
  parameter int N_CHAN    = 2,
  parameter int ENDP_BASE = ENDP_BASE_DEFAULT,
  parameter int IN_MPS    = 8,
  parameter int OUT_MPS   = 8,
  parameter int DEPTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  usb_reset_i,
  input  logic [ENDP_W-1:0]     endp_i,
  input  logic                  in_req_i,
  input  logic                  in_ready_i,
  input  logic                  in_data_ack_i,
  output logic [BYTE_W-1:0]     in_data_o,
  output logic                  in_valid_o,
  output logic                  in_zlp_o,
  input  logic [BYTE_W-1:0]     out_data_i,
  input  logic                  out_valid_i,
  input  logic                  out_commit_i,
  input  logic                  out_err_i,
  output logic                  out_nak_o,
  input  logic [8*N_CHAN-1:0]   app_in_data_i,
  input  logic [N_CHAN-1:0]     app_in_valid_i,
  output logic [N_CHAN-1:0]     app_in_ready_o,
  output logic [8*N_CHAN-1:0]   app_out_data_o,
  output logic [N_CHAN-1:0]     app_out_valid_o,
  input  logic [N_CHAN-1:0]     app_out_ready_i
);

  localparam int PW = p17_clog2(DEPTH) + 1;

  logic [N_CHAN-1:0]              ch_hit;
  logic [N_CHAN-1:0]              ch_in_valid;
  logic [N_CHAN-1:0]              ch_in_zlp;
  logic [N_CHAN-1:0]              ch_nak;
  logic [N_CHAN-1:0][BYTE_W-1:0]  ch_in_data;

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    localparam logic [ENDP_W-1:0] EP = ENDP_W'(ENDP_BASE + c);

    // ---------------- IN direction ----------------
    logic [PW-1:0]     iw_spec, iw_com, ir_com;
    logic [PW-1:0]     in_level, in_take;
    logic [BYTE_W-1:0] in_byte;
    logic              in_wr, in_rd, in_ack, in_restart;
    in_state_e         state_q, state_d;
    logic [PW-1:0]     cnt_q, cnt_d, len_q, len_d;
    logic              zlp_q, zlp_d;

    assign ch_hit[c] = (endp_i == EP);

    assign app_in_ready_o[c] = (iw_spec - ir_com) < PW'(DEPTH);
    assign in_wr             = app_in_valid_i[c] & app_in_ready_o[c];

    // Packet size is taken from committed data so a retransmit resends it all.
    assign in_level   = iw_com - ir_com;
    assign in_take    = (in_level > PW'(IN_MPS)) ? PW'(IN_MPS) : in_level;
    assign in_restart = ch_hit[c] & in_req_i;
    assign in_ack     = ch_hit[c] & in_data_ack_i & (state_q != IN_IDLE);
    assign in_rd      = ch_in_valid[c] & in_ready_i;

    assign ch_in_valid[c] = ch_hit[c] & (state_q == IN_SEND) & (cnt_q != '0);
    assign ch_in_zlp[c]   = ch_hit[c] & (state_q == IN_SEND) & (len_q == '0) & zlp_q;
    assign ch_in_data[c]  = in_byte;

    p17_spec_fifo #(.DEPTH(DEPTH), .PW(PW)) u_in_fifo (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .flush_i       (usb_reset_i),
      .wr_en_i       (in_wr),
      .wr_data_i     (app_in_data_i[c*8 +: 8]),
      .wr_commit_i   (in_wr),
      .wr_rollback_i (1'b0),
      .rd_en_i       (in_rd),
      .rd_commit_i   (in_ack),
      .rd_rollback_i (in_restart),
      .rd_data_o     (in_byte),
      .wr_spec_o     (iw_spec),
      .wr_com_o      (iw_com),
      .rd_com_o      (ir_com)
    );

    // IN transfer state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        state_q <= IN_IDLE;
        cnt_q   <= '0;
        len_q   <= '0;
        zlp_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        len_q   <= len_d;
        zlp_q   <= zlp_d;
      end
    end

    // IN next state: bus reset, then new token, then ack, then byte progress.
    // A zero-length packet stays in SEND until acked or re-requested.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      zlp_d   = zlp_q;
      if (usb_reset_i) begin
        state_d = IN_IDLE;
        cnt_d   = '0;
        len_d   = '0;
        zlp_d   = 1'b0;
      end else if (in_restart) begin
        state_d = IN_SEND;
        cnt_d   = in_take;
        len_d   = in_take;
      end else if (in_ack) begin
        state_d = IN_IDLE;
        cnt_d   = '0;
        zlp_d   = (len_q == PW'(IN_MPS));
      end else if (in_rd) begin
        cnt_d = cnt_q - PW'(1);
        if (cnt_q == PW'(1)) state_d = IN_WAIT_ACK;
      end
    end

    // ---------------- OUT direction ----------------
    logic [PW-1:0] ow_spec, ow_com, or_com, o_fill;
    logic          o_full, o_wr, o_commit, o_roll, o_read, bad_q;

    assign o_fill    = ow_spec - or_com;
    assign o_full    = (o_fill == PW'(DEPTH));
    assign ch_nak[c] = ch_hit[c] & (o_fill > PW'(DEPTH - OUT_MPS));
    assign o_wr      = ch_hit[c] & out_valid_i & ~o_full;
    assign o_commit  = ch_hit[c] & out_commit_i & ~bad_q;
    assign o_roll    = ch_hit[c] & (out_err_i | (out_commit_i & bad_q));

    assign app_out_valid_o[c] = (ow_com != or_com);
    assign o_read             = app_out_valid_o[c] & app_out_ready_i[c];

    p17_spec_fifo #(.DEPTH(DEPTH), .PW(PW)) u_out_fifo (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .flush_i       (usb_reset_i),
      .wr_en_i       (o_wr),
      .wr_data_i     (out_data_i),
      .wr_commit_i   (o_commit),
      .wr_rollback_i (o_roll),
      .rd_en_i       (o_read),
      .rd_commit_i   (o_read),
      .rd_rollback_i (1'b0),
      .rd_data_o     (app_out_data_o[c*8 +: 8]),
      .wr_spec_o     (ow_spec),
      .wr_com_o      (ow_com),
      .rd_com_o      (or_com)
    );

    // Bad-packet flag: set by a dropped byte, cleared when the packet ends.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        bad_q <= 1'b0;
      end else if (usb_reset_i) begin
        bad_q <= 1'b0;
      end else if (ch_hit[c] & (out_commit_i | out_err_i)) begin
        bad_q <= 1'b0;
      end else if (ch_hit[c] & out_valid_i & o_full) begin
        bad_q <= 1'b1;
      end
    end
  end

  assign in_valid_o = |ch_in_valid;
  assign in_zlp_o   = |ch_in_zlp;
  assign out_nak_o  = |ch_nak;

  // IN byte comes from whichever channel the current token addresses.
  always_comb begin
    in_data_o = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      if (ch_hit[c]) in_data_o = ch_in_data[c];
    end
  end

endmodule
